// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int ITER = 32;
  localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_absneg.sv
// Conditional two's-complement negate; used for operand magnitude and result sign fix.
module mdu_absneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mdu_hilo #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER);

  state_e              state_r, state_s;
  logic [CW-1:0]       count_r;
  logic                div_r;
  logic                neg_res_r;
  logic                neg_rem_r;
  logic                dz_r;
  logic [XLEN-1:0]     raw_a_r;
  logic [XLEN-1:0]     opnd_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     hi_r, lo_r;
  logic                busy_r, done_r;

  logic                a_neg_s, b_neg_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic [XLEN:0]       mul_sum_s;
  logic [2*XLEN-1:0]   mul_next_s;
  logic [XLEN:0]       div_shift_s;
  logic [XLEN:0]       div_trial_s;
  logic [2*XLEN-1:0]   div_next_s;
  logic [2*XLEN-1:0]   step_s;
  logic [2*XLEN-1:0]   prod_fix_s;
  logic [XLEN-1:0]     quot_fix_s, rem_fix_s;

  assign a_neg_s = op_is_signed(op) & rs_data[XLEN-1];
  assign b_neg_s = op_is_signed(op) & rt_data[XLEN-1];

  mdu_absneg #(.W(XLEN)) u_abs_a (.val(rs_data), .neg(a_neg_s), .res(a_mag_s));
  mdu_absneg #(.W(XLEN)) u_abs_b (.val(rt_data), .neg(b_neg_s), .res(b_mag_s));

  mdu_absneg #(.W(2*XLEN)) u_fix_prod (.val(acc_r), .neg(neg_res_r), .res(prod_fix_s));
  mdu_absneg #(.W(XLEN)) u_fix_quot (.val(acc_r[XLEN-1:0]), .neg(neg_res_r), .res(quot_fix_s));
  mdu_absneg #(.W(XLEN)) u_fix_rem (.val(acc_r[2*XLEN-1:XLEN]), .neg(neg_rem_r), .res(rem_fix_s));

  // One iteration: shift-add multiply or restoring shift-subtract divide.
  // For divide, acc holds {remainder, dividend/quotient}; for multiply {partial sum, multiplier}.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                  {1'b0, (acc_r[0] ? opnd_r : {XLEN{1'b0}})};
    mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
    div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    div_next_s  = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    if (!div_trial_s[XLEN]) begin
      div_next_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end
    if (div_r) begin
      step_s = div_next_s;
    end else begin
      step_s = mul_next_s;
    end
  end

  // Next-state logic for IDLE -> RUN -> FIX -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (count_r == CW'(ITER-1)) begin
          state_s = S_FIX;
        end else begin
          state_s = S_RUN;
        end
      end
      S_FIX:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register, operand latch, iteration datapath and HI/LO update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      count_r   <= {CW{1'b0}};
      div_r     <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      raw_a_r   <= {XLEN{1'b0}};
      opnd_r    <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      hi_r      <= {XLEN{1'b0}};
      lo_r      <= {XLEN{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            div_r     <= op_is_div(op);
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            dz_r      <= (rt_data == {XLEN{1'b0}});
            raw_a_r   <= rs_data;
            count_r   <= {CW{1'b0}};
            opnd_r    <= op_is_div(op) ? b_mag_s : a_mag_s;
            acc_r     <= {{XLEN{1'b0}}, (op_is_div(op) ? a_mag_s : b_mag_s)};
          end else begin
            if (mthi) hi_r <= wr_data;
            if (mtlo) lo_r <= wr_data;
          end
        end
        S_RUN: begin
          acc_r   <= step_s;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          done_r <= 1'b1;
          if (!div_r) begin
            hi_r <= prod_fix_s[2*XLEN-1:XLEN];
            lo_r <= prod_fix_s[XLEN-1:0];
          end else if (dz_r) begin
            // Divide by zero returns the raw dividend, unaffected by sign handling.
            hi_r <= raw_a_r;
            lo_r <= DZ_QUOT;
          end else begin
            hi_r <= rem_fix_s;
            lo_r <= quot_fix_s;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo with hand-computed HI/LO results.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_pass = 0;

  mdu_hilo #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op, optionally inject start+mthi around cycle junk_at, and check timing.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int junk_at);
    int n;
    int busy_cnt;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    check_eq({tag, "_busy_e0"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    n = 0; busy_cnt = 1; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
      if (junk_at != 0 && n == junk_at) begin
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 32'h7; rt_data = 32'h7;
        mthi = 1'b1; wr_data = 32'h0000_DEAD;
      end else if (junk_at != 0 && n == junk_at + 1) begin
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
      end
    end
    check_eq({tag, "_latency"}, 32'(n), 32'd33);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check_eq({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_done_once"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #12;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_hi", hi, 32'h0);
    check_eq("rst_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_eq("multu_max_hi", hi, 32'hFFFF_FFFE);
    check_eq("multu_max_lo", lo, 32'h0000_0001);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    check_eq("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_neg_lo", lo, 32'hFFFF_FFEB);

    @(negedge clk);
    mtlo = 1'b1; wr_data = 32'h1234_5678;
    @(posedge clk); #1;
    check_eq("mtlo_lo", lo, 32'h1234_5678);
    check_eq("mtlo_hi", hi, 32'hFFFF_FFFF);
    check_eq("mtlo_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    mtlo = 1'b0; mthi = 1'b1; wr_data = 32'hCAFE_0001;
    @(posedge clk); #1;
    check_eq("mthi_hi", hi, 32'hCAFE_0001);
    check_eq("mthi_lo", lo, 32'h1234_5678);
    @(negedge clk);
    mthi = 1'b0;

    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    check_eq("mult_minmin_hi", hi, 32'h4000_0000);
    check_eq("mult_minmin_lo", lo, 32'h0000_0000);

    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    check_eq("div_neg_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op("divu", 2'b11, 32'd100, 32'd7, 0);
    check_eq("divu_lo", lo, 32'd14);
    check_eq("divu_hi", hi, 32'd2);

    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_eq("div_ovf_lo", lo, 32'h8000_0000);
    check_eq("div_ovf_hi", hi, 32'h0000_0000);

    run_op("divu_dz", 2'b11, 32'd5, 32'd0, 0);
    check_eq("divu_dz_lo", lo, 32'hFFFF_FFFF);
    check_eq("divu_dz_hi", hi, 32'd5);

    run_op("div_dz", 2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    check_eq("div_dz_lo", lo, 32'hFFFF_FFFF);
    check_eq("div_dz_hi", hi, 32'hFFFF_FFFB);

    run_op("busy_ign", 2'b11, 32'd9, 32'd3, 9);
    check_eq("busy_ign_lo", lo, 32'd3);
    check_eq("busy_ign_hi", hi, 32'd0);

    // Abort a run with reset mid-flight.
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = 32'd9; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_hi", hi, 32'h0);
    check_eq("abort_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcnt = 0;
      int bcnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done) dcnt++;
        if (busy) bcnt++;
      end
      check_eq("abort_no_done", 32'(dcnt), 32'd0);
      check_eq("abort_no_busy", 32'(bcnt), 32'd0);
    end
    check_eq("abort_lo_after", lo, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS core. It sits directly downstream of the register file read ports and consumes the rs/rt operand values for MULT/MULTU/DIV/DIVU. It holds HI/LO for MFHI/MFLO, whose results the writeback path returns to the register file write port. It exposes busy so the decode stage stalls HI/LO-dependent instructions.

Parameters:
XLEN, 32, operand width; HI/LO each XLEN bits.
ITER, 32, iteration count per operation; must equal XLEN.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  launch the operation selected by op; accepted only in IDLE.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
rs_data  input  32  operand A (multiplicand / dividend), from register file read port 1.
rt_data  input  32  operand B (multiplier / divisor), from register file read port 2.
mthi  input  1  write wr_data to HI.
mtlo  input  1  write wr_data to LO.
wr_data  input  32  MTHI/MTLO source value.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse when HI/LO take a new result.
hi  output  32  HI register.
lo  output  32  LO register.

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE; busy=0, done=0, hi=0, lo=0; internal counters and accumulators cleared. Reset during RUN/FIX aborts the operation, and no result is written.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE with start=1 at edge E0:
  - Latch op and the magnitudes of rs_data/rt_data. Signed ops use the two's-complement absolute value; 0x80000000 becomes unsigned 0x80000000.
  - Latch the result sign flags; clear count; go to RUN; busy=1 from E0.
- RUN: one iteration per edge, E1..E32.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - The count==ITER-1 edge moves the FSM to FIX.
- FIX, edge E33: apply sign correction, write hi/lo, return to IDLE, busy=0, done=1 for exactly the cycle after E33. Result is visible on hi/lo 33 edges after the start edge.
- Sign rules:
  - Signed product: negate the 64-bit result if the operand signs differ.
  - Signed quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
- Results: multiply gives hi=product[63:32], lo=product[31:0]. Divide gives lo=quotient, hi=remainder.
- Divide by zero (either signedness): lo=0xFFFFFFFF, hi=rs_data as latched (raw value, no sign fix).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored; the in-flight operation is unaffected.
- mthi/mtlo while busy: ignored.
- mthi/mtlo in IDLE: the register is written at the edge; mthi and mtlo together write both.
- start with mthi/mtlo in the same IDLE cycle: start wins, and the moves are dropped.
- Operands are sampled only at the start edge; later changes on rs_data/rt_data have no effect.
- done is low in every cycle except the one after FIX. An MTHI/MTLO write never raises done.

Decomposition:
- Package mdu_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encoding S_IDLE/S_RUN/S_FIX;
  - constant ITER=32;
  - the divide-by-zero quotient constant 0xFFFFFFFF.
- One natural sub-module, mdu_absneg: combinational conditional two's-complement negate, parameterised width. It is instantiated for operand abs (32-bit) and result fix (32/64-bit).

Test Plan:
- MULTU with rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles, done pulses once, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MTLO 0x12345678 in IDLE -> lo=0x12345678 next edge, hi unchanged, done stays 0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
- Start DIVU 9/3, then at cycle 10:
  - assert start with a MULTU and mthi with wr_data=0xDEAD -> both ignored; result lo=3, hi=0 at E33.
  - Repeat the run and pull rst_n low at cycle 20 -> busy=0, hi=lo=0 immediately, and no done pulse follows.
